// File: rtl/ysyx_22040759_bru_bp.sv
// Branch resolve unit with a direct-mapped predictor (2-bit BHT + tagged BTB).
// IF looks the tables up combinationally; EX resolves, trains and issues a registered redirect.
module ysyx_22040759_bru_bp #(
   parameter int XLEN  = 64,
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             ex_valid,
   input  logic [4:0]       ex_sel,
   input  logic [XLEN-1:0]  ex_src1,
   input  logic [XLEN-1:0]  ex_src2,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mis_cnt
);
   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [4:0] BLU_JAL  = 5'd1;
   localparam logic [4:0] BLU_JALR = 5'd2;
   localparam logic [4:0] BLU_BEQ  = 5'd3;
   localparam logic [4:0] BLU_BNE  = 5'd4;
   localparam logic [4:0] BLU_BLT  = 5'd5;
   localparam logic [4:0] BLU_BGE  = 5'd6;
   localparam logic [4:0] BLU_BLTU = 5'd7;
   localparam logic [4:0] BLU_BGEU = 5'd8;

   logic [1:0]      bht_rd        [DEPTH];
   logic            btb_valid_rd  [DEPTH];
   logic [TAG_W-1:0] btb_tag_rd   [DEPTH];
   logic [XLEN-1:0] btb_target_rd [DEPTH];
   logic            btb_jump_rd   [DEPTH];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx      = if_pc[IDX_W+1:2];
   assign if_tag      = if_pc[XLEN-1:IDX_W+2];
   assign if_hit      = btb_valid_rd[if_idx] && (btb_tag_rd[if_idx] == if_tag);
   assign pred_taken  = if_hit && (btb_jump_rd[if_idx] || bht_rd[if_idx][1]);
   assign pred_target = if_hit ? btb_target_rd[if_idx] : if_pc + XLEN'(4);

   logic             is_ctrl, is_jump, is_jalr, taken;
   logic             eq, lt, ltu;
   logic [XLEN-1:0]  target, seq_pc, next_pc;
   logic             is_br, alias_mis, mispredict, upd_en, clr_en;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;

   always_comb begin
      eq      = (ex_src1 == ex_src2);
      lt      = ($signed(ex_src1) < $signed(ex_src2));
      ltu     = (ex_src1 < ex_src2);
      is_ctrl = 1'b1;
      is_jump = 1'b0;
      taken   = 1'b0;
      case (ex_sel)
         BLU_JAL, BLU_JALR: begin
            is_jump = 1'b1;
            taken   = 1'b1;
         end
         BLU_BEQ:  taken = eq;
         BLU_BNE:  taken = !eq;
         BLU_BLT:  taken = lt;
         BLU_BGE:  taken = !lt;
         BLU_BLTU: taken = ltu;
         BLU_BGEU: taken = !ltu;
         default:  is_ctrl = 1'b0;
      endcase
      is_jalr = (ex_sel == BLU_JALR);
      target  = (is_jalr ? ex_src1 : ex_pc) + ex_imm;
      if (is_jalr) target[0] = 1'b0;
      seq_pc  = ex_pc + XLEN'(4);
      is_br   = ex_valid && is_ctrl;
      // A fetch-side hit on a non-control instruction means the BTB entry is a stale alias.
      alias_mis  = ex_valid && !is_ctrl && ex_pred_taken;
      mispredict = (is_br && ((taken != ex_pred_taken) ||
                              (taken && (target != ex_pred_target)))) || alias_mis;
      next_pc = (is_br && taken) ? target : seq_pc;
      upd_en  = is_br && !flush;
      clr_en  = alias_mis && !flush;
      ex_idx  = ex_pc[IDX_W+1:2];
      ex_tag  = ex_pc[XLEN-1:IDX_W+2];
   end

   logic             redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

   always_comb begin
      redirect_valid_d = mispredict && !flush;
      redirect_pc_d    = redirect_valid_d ? next_pc : redirect_pc_q;
      br_cnt_d         = (upd_en && br_cnt_q != CNT_MAX) ? br_cnt_q + 1'b1 : br_cnt_q;
      mis_cnt_d        = (redirect_valid_d && mis_cnt_q != CNT_MAX) ? mis_cnt_q + 1'b1 : mis_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         br_cnt_q         <= '0;
         mis_cnt_q        <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         br_cnt_q         <= br_cnt_d;
         mis_cnt_q        <= mis_cnt_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign br_cnt         = br_cnt_q;
   assign mis_cnt        = mis_cnt_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             sel;
      logic [1:0]       bht_q, bht_d;
      logic             valid_q, valid_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [XLEN-1:0]  target_q, target_d;
      logic             jump_q, jump_d;

      assign sel = (ex_idx == IDX_W'(gi));

      always_comb begin
         bht_d    = bht_q;
         valid_d  = valid_q;
         tag_d    = tag_q;
         target_d = target_q;
         jump_d   = jump_q;
         if (sel && upd_en) begin
            if (taken) begin
               if (bht_q != 2'b11) bht_d = bht_q + 2'b01;
               valid_d  = 1'b1;
               tag_d    = ex_tag;
               target_d = target;
               jump_d   = is_jump;
            end else if (bht_q != 2'b00) begin
               bht_d = bht_q - 2'b01;
            end
         end else if (sel && clr_en) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            bht_q   <= 2'b01;
            valid_q <= 1'b0;
         end else begin
            bht_q   <= bht_d;
            valid_q <= valid_d;
         end
      end

      // Payload fields are qualified by valid, so they need no reset.
      always_ff @(posedge clk) begin
         tag_q    <= tag_d;
         target_q <= target_d;
         jump_q   <= jump_d;
      end

      assign bht_rd[gi]        = bht_q;
      assign btb_valid_rd[gi]  = valid_q;
      assign btb_tag_rd[gi]    = tag_q;
      assign btb_target_rd[gi] = target_q;
      assign btb_jump_rd[gi]   = jump_q;
   end

endmodule

// File: tb/tb_ysyx_22040759_bru_bp.sv
// Bench for ysyx_22040759_bru_bp: directed vector table, hand sequences and random
// traffic checked against an array-based predictor model.
module tb_ysyx_22040759_bru_bp;
   localparam int XLEN  = 64;
   localparam int IDX_W = 6;
   localparam int CNT_W = 32;

   localparam logic [4:0] OP_NONE = 5'd0;
   localparam logic [4:0] OP_JAL  = 5'd1;
   localparam logic [4:0] OP_JALR = 5'd2;
   localparam logic [4:0] OP_BEQ  = 5'd3;
   localparam logic [4:0] OP_BNE  = 5'd4;
   localparam logic [4:0] OP_BLT  = 5'd5;
   localparam logic [4:0] OP_BGE  = 5'd6;
   localparam logic [4:0] OP_BLTU = 5'd7;
   localparam logic [4:0] OP_BGEU = 5'd8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [XLEN-1:0]  if_pc;
   logic             pred_taken;
   logic [XLEN-1:0]  pred_target;
   logic             ex_valid;
   logic [4:0]       ex_sel;
   logic [XLEN-1:0]  ex_src1, ex_src2, ex_imm, ex_pc;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             flush;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] br_cnt, mis_cnt;

   always #5 clk = ~clk;

   ysyx_22040759_bru_bp #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .ex_valid(ex_valid), .ex_sel(ex_sel),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_pc(ex_pc),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .br_cnt(br_cnt), .mis_cnt(mis_cnt)
   );

   typedef struct {
      logic [63:0] if_pc;
      logic        ex_valid;
      logic [4:0]  op;
      logic [63:0] s1, s2, imm, pc;
      logic        pt;
      logic [63:0] ptgt;
      logic        flush;
   } txn_t;

   typedef struct {
      txn_t        t;
      logic        exp_pt;
      logic [63:0] exp_ptgt;
      logic        exp_rv;
      logic [63:0] exp_rpc;
      int          exp_br;
      int          exp_mis;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one record per predictor slot, plus the architectural outputs.
   int          m_bht [64];
   bit          m_val [64];
   logic [63:0] m_tag [64];
   logic [63:0] m_tgt [64];
   bit          m_jmp [64];
   longint      m_br, m_mis;
   bit          m_rv;
   logic [63:0] m_rpc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc / 64'd4) % 64'd64);
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] pc);
      return pc / 64'd256;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 64; i++) begin
         m_bht[i] = 1;
         m_val[i] = 0;
      end
      m_br = 0; m_mis = 0; m_rv = 0; m_rpc = '0;
   endfunction

   function automatic void m_predict(input logic [63:0] pc, output logic pt, output logic [63:0] tgt);
      int i;
      bit hit;
      i   = idx_of(pc);
      hit = m_val[i] && (m_tag[i] == tag_of(pc));
      pt  = hit && (m_jmp[i] || m_bht[i] >= 2);
      tgt = hit ? m_tgt[i] : pc + 64'd4;
   endfunction

   function automatic void m_commit(input txn_t t);
      bit          is_br, taken, mis;
      logic [63:0] tgt, nxt;
      int          i;
      is_br = t.ex_valid && (t.op >= OP_JAL) && (t.op <= OP_BGEU);
      case (t.op)
         OP_JAL, OP_JALR: taken = 1;
         OP_BEQ:  taken = (t.s1 == t.s2);
         OP_BNE:  taken = (t.s1 != t.s2);
         OP_BLT:  taken = ($signed(t.s1) <  $signed(t.s2));
         OP_BGE:  taken = ($signed(t.s1) >= $signed(t.s2));
         OP_BLTU: taken = (t.s1 <  t.s2);
         OP_BGEU: taken = (t.s1 >= t.s2);
         default: taken = 0;
      endcase
      tgt = (t.op == OP_JALR) ? ((t.s1 + t.imm) & ~64'd1) : (t.pc + t.imm);
      mis = is_br ? ((taken != t.pt) || (taken && tgt != t.ptgt)) : (t.ex_valid && t.pt);
      nxt = (is_br && taken) ? tgt : t.pc + 64'd4;
      i   = idx_of(t.pc);
      m_rv = !t.flush && mis;
      if (m_rv) begin
         m_rpc = nxt;
         if (m_mis < 64'hFFFF_FFFF) m_mis++;
      end
      if (!t.flush && is_br) begin
         if (m_br < 64'hFFFF_FFFF) m_br++;
         m_bht[i] = taken ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
         if (taken) begin
            m_val[i] = 1; m_tag[i] = tag_of(t.pc); m_tgt[i] = tgt;
            m_jmp[i] = (t.op == OP_JAL) || (t.op == OP_JALR);
         end
      end else if (!t.flush && !is_br && mis) begin
         m_val[i] = 0;
      end
   endfunction

   function automatic txn_t mk(input logic [63:0] ifpc, input logic [4:0] op,
                               input logic [63:0] s1, input logic [63:0] s2,
                               input logic [63:0] imm, input logic [63:0] pc,
                               input logic pt, input logic [63:0] ptgt, input logic fl);
      txn_t t;
      t.if_pc = ifpc; t.ex_valid = 1'b1; t.op = op; t.s1 = s1; t.s2 = s2;
      t.imm = imm; t.pc = pc; t.pt = pt; t.ptgt = ptgt; t.flush = fl;
      return t;
   endfunction

   task automatic drive(input txn_t t);
      if_pc = t.if_pc; ex_valid = t.ex_valid; ex_sel = t.op;
      ex_src1 = t.s1; ex_src2 = t.s2; ex_imm = t.imm; ex_pc = t.pc;
      ex_pred_taken = t.pt; ex_pred_target = t.ptgt; flush = t.flush;
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic run_txn(input txn_t t, output logic o_pt, output logic [63:0] o_ptgt,
                          output logic o_rv, output logic [63:0] o_rpc,
                          output logic [63:0] o_br, output logic [63:0] o_mis);
      logic        e_pt;
      logic [63:0] e_ptgt;
      drive(t);
      @(negedge clk);
      m_predict(t.if_pc, e_pt, e_ptgt);
      o_pt = pred_taken; o_ptgt = pred_target;
      chk("model pred_taken", 64'(pred_taken), 64'(e_pt));
      chk("model pred_target", pred_target, e_ptgt);
      @(posedge clk);
      #1;
      m_commit(t);
      o_rv = redirect_valid; o_rpc = redirect_pc; o_br = 64'(br_cnt); o_mis = 64'(mis_cnt);
      chk("model redirect_valid", 64'(redirect_valid), 64'(m_rv));
      chk("model redirect_pc", redirect_pc, m_rpc);
      chk("model br_cnt", 64'(br_cnt), 64'(m_br));
      chk("model mis_cnt", 64'(mis_cnt), 64'(m_mis));
      $display("txn op=%0d v=%0b ex_pc=%h fl=%0b pt=%0b -> rv=%0b rpc=%h br=%0d mis=%0d",
               t.op, t.ex_valid, t.pc, t.flush, t.pt, redirect_valid, redirect_pc, br_cnt, mis_cnt);
   endtask

   function automatic logic [63:0] rnd_pc();
      logic [63:0] base;
      base = ($urandom_range(0, 3) == 0) ? 64'h8001_0000 : 64'h8000_0000;
      return base + 64'($urandom_range(0, 15)) * 64'd4;
   endfunction

   function automatic logic [63:0] rnd_src();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'd1;
         2: return '1;
         3: return 64'h8000_0000_0000_0000;
         4: return {$urandom, $urandom};
         default: return 64'd5;
      endcase
   endfunction

   vec_t        vecs [10];
   bit          sat_exp [10] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
   txn_t        t;
   logic        o_pt, o_rv;
   logic [63:0] o_ptgt, o_rpc, o_br, o_mis;

   initial begin
      vecs[0] = '{mk(64'h80000010, OP_BEQ, 64'd5, 64'd5, 64'h20, 64'h80000100, 1'b0, 64'h0, 1'b0),
                  1'b0, 64'h80000014, 1'b1, 64'h80000120, 1, 1};
      vecs[1] = '{mk(64'h80000100, OP_JALR, 64'h80001003, 64'd0, 64'd4, 64'h80000204, 1'b1, 64'h80001006, 1'b0),
                  1'b1, 64'h80000120, 1'b0, 64'h80000120, 2, 1};
      vecs[2] = '{mk(64'h80000204, OP_JALR, 64'h80001003, 64'd0, 64'd4, 64'h80000204, 1'b1, 64'h80001000, 1'b0),
                  1'b1, 64'h80001006, 1'b1, 64'h80001006, 3, 2};
      vecs[3] = '{mk(64'h80000010, OP_BLT, '1, 64'd1, 64'h40, 64'h80000308, 1'b1, 64'h80000348, 1'b0),
                  1'b0, 64'h80000014, 1'b0, 64'h80001006, 4, 2};
      vecs[4] = '{mk(64'h80000308, OP_BLTU, '1, 64'd1, 64'h40, 64'h8000030C, 1'b1, 64'h8000034C, 1'b0),
                  1'b1, 64'h80000348, 1'b1, 64'h80000310, 5, 3};
      vecs[5] = '{mk(64'h8000030C, OP_BNE, 64'd1, 64'd2, 64'h10, 64'h80000400, 1'b0, 64'h0, 1'b0),
                  1'b0, 64'h80000310, 1'b1, 64'h80000410, 6, 4};
      vecs[6] = '{mk(64'h80000400, OP_BGE, 64'd3, 64'd1, 64'h8, 64'h80000500, 1'b0, 64'h0, 1'b1),
                  1'b1, 64'h80000410, 1'b0, 64'h80000410, 6, 4};
      vecs[7] = '{mk(64'h80000500, OP_NONE, 64'd0, 64'd0, 64'd0, 64'h80000400, 1'b1, 64'h80000410, 1'b0),
                  1'b0, 64'h80000504, 1'b1, 64'h80000404, 6, 5};
      vecs[8] = '{mk(64'h80000400, OP_BGEU, 64'd1, '1, 64'h8, 64'h80000600, 1'b0, 64'h0, 1'b0),
                  1'b0, 64'h80000404, 1'b0, 64'h80000404, 7, 5};
      vecs[9] = '{mk(64'h80000204, OP_JAL, 64'd0, 64'd0, -64'sd8, 64'h80000704, 1'b0, 64'h0, 1'b0),
                  1'b1, 64'h80001006, 1'b1, 64'h800006FC, 8, 6};

      rst_n = 1'b0;
      t = mk(64'h80000010, OP_NONE, 0, 0, 0, 64'h80000000, 1'b0, 0, 1'b0);
      t.ex_valid = 1'b0;
      drive(t);
      m_reset();
      #3;
      chk("reset redirect_valid", 64'(redirect_valid), 64'd0);
      chk("reset redirect_pc", redirect_pc, 64'd0);
      chk("reset br_cnt", 64'(br_cnt), 64'd0);
      chk("reset mis_cnt", 64'(mis_cnt), 64'd0);
      chk("reset pred_taken", 64'(pred_taken), 64'd0);
      chk("reset pred_target", pred_target, 64'h80000014);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].t, o_pt, o_ptgt, o_rv, o_rpc, o_br, o_mis);
         chk($sformatf("vec%0d pred_taken", i), 64'(o_pt), 64'(vecs[i].exp_pt));
         chk($sformatf("vec%0d pred_target", i), o_ptgt, vecs[i].exp_ptgt);
         chk($sformatf("vec%0d redirect_valid", i), 64'(o_rv), 64'(vecs[i].exp_rv));
         chk($sformatf("vec%0d redirect_pc", i), o_rpc, vecs[i].exp_rpc);
         chk($sformatf("vec%0d br_cnt", i), o_br, 64'(vecs[i].exp_br));
         chk($sformatf("vec%0d mis_cnt", i), o_mis, 64'(vecs[i].exp_mis));
      end

      // BHT saturation on one slot: 4 taken, 5 not-taken, 1 taken.
      for (int k = 0; k < 10; k++) begin
         t = mk(64'h80000014, OP_BEQ, 64'd7, (k < 4 || k == 9) ? 64'd7 : 64'd8,
                64'h40, 64'h80000014, 1'b0, 64'h0, 1'b0);
         m_predict(t.pc, t.pt, t.ptgt);
         run_txn(t, o_pt, o_ptgt, o_rv, o_rpc, o_br, o_mis);
         chk($sformatf("sat%0d pred_taken", k), 64'(o_pt), 64'(sat_exp[k]));
      end

      // Asynchronous reset while a redirect pulse is being presented.
      t = mk(64'h80000800, OP_JAL, 0, 0, 64'h100, 64'h80000800, 1'b0, 64'h0, 1'b0);
      run_txn(t, o_pt, o_ptgt, o_rv, o_rpc, o_br, o_mis);
      chk("pre-reset redirect_valid", 64'(o_rv), 64'd1);
      chk("pre-reset redirect_pc", o_rpc, 64'h80000900);
      ex_valid = 1'b0;
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("midreset redirect_valid", 64'(redirect_valid), 64'd0);
      chk("midreset redirect_pc", redirect_pc, 64'd0);
      chk("midreset br_cnt", 64'(br_cnt), 64'd0);
      chk("midreset mis_cnt", 64'(mis_cnt), 64'd0);
      chk("midreset pred_taken", 64'(pred_taken), 64'd0);
      chk("midreset pred_target", pred_target, 64'h80000804);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postreset redirect_valid", 64'(redirect_valid), 64'd0);

      for (int n = 0; n < 300; n++) begin
         logic [3:0] opr;
         int         imm_i;
         opr       = 4'($urandom_range(0, 9));
         t.if_pc   = rnd_pc();
         t.ex_valid = ($urandom_range(0, 7) != 0);
         t.op      = {1'b0, opr};
         t.s1      = rnd_src();
         t.s2      = ($urandom_range(0, 3) == 0) ? t.s1 : rnd_src();
         imm_i     = int'($urandom_range(0, 63)) * 4 - 128;
         t.imm     = 64'(longint'(imm_i));
         t.pc      = rnd_pc();
         if ($urandom_range(0, 9) < 7) begin
            m_predict(t.pc, t.pt, t.ptgt);
         end else begin
            t.pt   = 1'($urandom_range(0, 1));
            t.ptgt = rnd_pc();
         end
         t.flush = ($urandom_range(0, 7) == 0);
         run_txn(t, o_pt, o_ptgt, o_rv, o_rpc, o_br, o_mis);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
